// File: rtl/i2c_codec_reg_slave.sv
// I2C write-only responder for 3-byte codec register frames [DEV+W, SUB, DATA].
// The 16-bit word {byte1, byte2} splits as {7-bit register address, 9-bit data}.
//
// state  | meaning
// IDLE   | bus free, waiting for START
// ADDR   | shifting in the slave address byte
// ACK_A  | driving ACK for a matching address
// BYTE1  | shifting in register address + data MSB
// ACK_1  | driving ACK for byte 1
// BYTE2  | shifting in data[7:0]
// ACK_2  | driving ACK for byte 2 (write already issued)
// IGNORE | not our frame, or extra bytes: SDA released until STOP/START
module i2c_codec_reg_slave #(
   parameter logic [6:0] DEV_ADDR = 7'h1A,
   parameter int         FILT_LEN = 4
) (
   input  logic       iCLK,
   input  logic       iRST,
   input  logic       iI2C_SCLK,
   input  logic       iI2C_SDAT,
   output logic       oSDAT_OE,
   output logic [6:0] oREG_ADDR,
   output logic [8:0] oREG_DATA,
   output logic       oREG_WE,
   output logic       oBUSY,
   output logic       oERR
);

   typedef enum logic [2:0] {
      IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, IGNORE
   } state_t;

   localparam logic [3:0] FILT_TC = 4'(FILT_LEN - 1);

   logic       scl_s1, scl_s2, sda_s1, sda_s2;
   logic       scl_f, sda_f, scl_q, sda_q;
   logic [3:0] scl_cnt, sda_cnt;

   state_t     state, state_nxt;
   logic [2:0] bit_cnt, bit_nxt;
   logic [6:0] shreg, sh_nxt;
   logic [7:0] byte1, byte1_nxt;
   logic       matched, matched_nxt;
   logic       written, written_nxt;
   logic       oe_nxt, busy_nxt, we_nxt, err_nxt;
   logic [6:0] addr_nxt;
   logic [8:0] data_nxt;

   logic       scl_rise, scl_fall, start_det, stop_det;
   logic [7:0] byte_full;

   // Two-flop synchronizers; idle bus level is high.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         scl_s1 <= 1'b1;
         scl_s2 <= 1'b1;
         sda_s1 <= 1'b1;
         sda_s2 <= 1'b1;
      end else begin
         scl_s1 <= iI2C_SCLK;
         scl_s2 <= scl_s1;
         sda_s1 <= iI2C_SDAT;
         sda_s2 <= sda_s1;
      end
   end

   // Glitch filter: a new level is accepted after FILT_LEN consecutive samples (down-count to zero).
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         scl_f   <= 1'b1;
         sda_f   <= 1'b1;
         scl_cnt <= FILT_TC;
         sda_cnt <= FILT_TC;
      end else begin
         if (scl_s2 == scl_f) begin
            scl_cnt <= FILT_TC;
         end else if (scl_cnt == 4'd0) begin
            scl_f   <= scl_s2;
            scl_cnt <= FILT_TC;
         end else begin
            scl_cnt <= scl_cnt - 4'd1;
         end
         if (sda_s2 == sda_f) begin
            sda_cnt <= FILT_TC;
         end else if (sda_cnt == 4'd0) begin
            sda_f   <= sda_s2;
            sda_cnt <= FILT_TC;
         end else begin
            sda_cnt <= sda_cnt - 4'd1;
         end
      end
   end

   // Previous filtered levels for edge and START/STOP detection.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         scl_q <= 1'b1;
         sda_q <= 1'b1;
      end else begin
         scl_q <= scl_f;
         sda_q <= sda_f;
      end
   end

   assign scl_rise  = scl_f & ~scl_q;
   assign scl_fall  = ~scl_f & scl_q;
   assign start_det = scl_f & scl_q & sda_q & ~sda_f;
   assign stop_det  = scl_f & scl_q & ~sda_q & sda_f;
   assign byte_full = {shreg, sda_f};

   // Next-state and output logic; START/STOP override everything else.
   always_comb begin
      state_nxt   = state;
      bit_nxt     = bit_cnt;
      sh_nxt      = shreg;
      byte1_nxt   = byte1;
      matched_nxt = matched;
      written_nxt = written;
      oe_nxt      = oSDAT_OE;
      busy_nxt    = oBUSY;
      addr_nxt    = oREG_ADDR;
      data_nxt    = oREG_DATA;
      we_nxt      = 1'b0;
      err_nxt     = 1'b0;
      if (start_det || stop_det) begin
         state_nxt   = start_det ? ADDR : IDLE;
         busy_nxt    = start_det;
         bit_nxt     = 3'd0;
         oe_nxt      = 1'b0;
         matched_nxt = 1'b0;
         written_nxt = 1'b0;
         err_nxt     = matched & ~written;
      end else begin
         case (state)
            ADDR, BYTE1, BYTE2: begin
               if (scl_rise) begin
                  sh_nxt  = byte_full[6:0];
                  bit_nxt = bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     if (state == ADDR) begin
                        if (byte_full == {DEV_ADDR, 1'b0}) begin
                           matched_nxt = 1'b1;
                           state_nxt   = ACK_A;
                        end else begin
                           state_nxt = IGNORE;
                        end
                     end else if (state == BYTE1) begin
                        byte1_nxt = byte_full;
                        state_nxt = ACK_1;
                     end else begin
                        addr_nxt    = byte1[7:1];
                        data_nxt    = {byte1[0], byte_full};
                        we_nxt      = 1'b1;
                        written_nxt = 1'b1;
                        state_nxt   = ACK_2;
                     end
                  end
               end
            end
            ACK_A, ACK_1, ACK_2: begin
               // First fall ends the 8th bit (grab SDA), second fall ends the ACK slot.
               if (scl_fall) begin
                  if (!oSDAT_OE) begin
                     oe_nxt = 1'b1;
                  end else begin
                     oe_nxt    = 1'b0;
                     state_nxt = (state == ACK_A) ? BYTE1 :
                                 (state == ACK_1) ? BYTE2 : IGNORE;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // State, datapath and registered outputs.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         state     <= IDLE;
         bit_cnt   <= 3'd0;
         shreg     <= 7'd0;
         byte1     <= 8'd0;
         matched   <= 1'b0;
         written   <= 1'b0;
         oSDAT_OE  <= 1'b0;
         oBUSY     <= 1'b0;
         oREG_ADDR <= 7'd0;
         oREG_DATA <= 9'd0;
         oREG_WE   <= 1'b0;
         oERR      <= 1'b0;
      end else begin
         state     <= state_nxt;
         bit_cnt   <= bit_nxt;
         shreg     <= sh_nxt;
         byte1     <= byte1_nxt;
         matched   <= matched_nxt;
         written   <= written_nxt;
         oSDAT_OE  <= oe_nxt;
         oBUSY     <= busy_nxt;
         oREG_ADDR <= addr_nxt;
         oREG_DATA <= data_nxt;
         oREG_WE   <= we_nxt;
         oERR      <= err_nxt;
      end
   end

endmodule

// File: tb/tb_i2c_codec_reg_slave.sv
// Directed bench for i2c_codec_reg_slave: an I2C master model drives frames,
// expected register writes go into a queue and are matched against oREG_WE.
module tb_i2c_codec_reg_slave;

   localparam int Q = 25;   // quarter SCL period in system clocks

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       m_scl = 1'b1;
   logic       m_sda = 1'b1;
   logic       glitch = 1'b0;
   logic       scl_line, sda_bus;
   logic       oe, we, busy, err;
   logic [6:0] reg_addr;
   logic [8:0] reg_data;

   int n_assert = 0;
   int n_fail   = 0;
   int we_cnt   = 0;
   int err_cnt  = 0;
   int oe_cnt   = 0;
   logic [15:0] exp_q[$];

   assign scl_line = m_scl ^ glitch;
   assign sda_bus  = m_sda & ~oe;

   i2c_codec_reg_slave #(.DEV_ADDR(7'h1A), .FILT_LEN(4)) dut (
      .iCLK      (clk),
      .iRST      (rst),
      .iI2C_SCLK (scl_line),
      .iI2C_SDAT (sda_bus),
      .oSDAT_OE  (oe),
      .oREG_ADDR (reg_addr),
      .oREG_DATA (reg_data),
      .oREG_WE   (we),
      .oBUSY     (busy),
      .oERR      (err)
   );

   always #10 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   // Scoreboard side: every write strobe must match the oldest expected write.
   always @(negedge clk) begin
      if (oe) oe_cnt++;
      if (err) err_cnt++;
      if (we) begin
         we_cnt++;
         chk("we_was_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0)
            chk("we_word", 32'({reg_addr, reg_data}), 32'(exp_q.pop_front()));
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic i2c_start();
      m_sda = 1'b1; tick(Q);
      m_scl = 1'b1; tick(Q);
      m_sda = 1'b0; tick(Q);
      m_scl = 1'b0; tick(Q);
   endtask

   task automatic i2c_stop();
      m_sda = 1'b0; tick(Q);
      m_scl = 1'b1; tick(Q);
      m_sda = 1'b1; tick(2 * Q);
   endtask

   task automatic send_bits(input logic [7:0] b, input bit g);
      for (int i = 7; i >= 0; i--) begin
         m_sda = b[i]; tick(Q);
         m_scl = 1'b1; tick(Q);
         if (g) begin glitch = 1'b1; tick(1); glitch = 1'b0; end
         tick(Q);
         m_scl = 1'b0;
         if (g) begin tick(Q / 2); glitch = 1'b1; tick(1); glitch = 1'b0; end
         tick(Q);
      end
   endtask

   task automatic ack_bit(output bit a);
      m_sda = 1'b1; tick(Q);
      m_scl = 1'b1; tick(Q);
      a = ~sda_bus;
      tick(Q);
      m_scl = 1'b0; tick(Q);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit exp_ack, input bit g, input string tag);
      bit a;
      send_bits(b, g);
      ack_bit(a);
      chk(tag, 32'(a), 32'(exp_ack));
   endtask

   task automatic push_exp(input logic [6:0] a, input logic [8:0] d);
      exp_q.push_back({a, d});
   endtask

   int we0, err0, oe0;

   initial begin
      tick(5);
      chk("rst_oe",   32'(oe),       32'd0);
      chk("rst_addr", 32'(reg_addr), 32'd0);
      chk("rst_data", 32'(reg_data), 32'd0);
      chk("rst_we",   32'(we),       32'd0);
      chk("rst_busy", 32'(busy),     32'd0);
      chk("rst_err",  32'(err),      32'd0);
      rst = 1'b0;
      tick(10);

      // Basic write 0x34 0x1E 0x00
      we0 = we_cnt; err0 = err_cnt;
      i2c_start();
      chk("f1_busy_in_frame", 32'(busy), 32'd1);
      send_byte(8'h34, 1'b1, 1'b0, "f1_ack_addr");
      send_byte(8'h1E, 1'b1, 1'b0, "f1_ack_b1");
      push_exp(7'h0F, 9'h000);
      send_byte(8'h00, 1'b1, 1'b0, "f1_ack_b2");
      i2c_stop();
      chk("f1_busy_after_stop", 32'(busy), 32'd0);
      chk("f1_we_count", 32'(we_cnt - we0), 32'd1);
      chk("f1_err_count", 32'(err_cnt - err0), 32'd0);

      // Back-to-back frames
      we0 = we_cnt;
      i2c_start();
      send_byte(8'h34, 1'b1, 1'b0, "b2b_ack_a0");
      send_byte(8'h08, 1'b1, 1'b0, "b2b_ack_a1");
      push_exp(7'h04, 9'h0F8);
      send_byte(8'hF8, 1'b1, 1'b0, "b2b_ack_a2");
      i2c_stop();
      i2c_start();
      send_byte(8'h34, 1'b1, 1'b0, "b2b_ack_b0");
      send_byte(8'h0F, 1'b1, 1'b0, "b2b_ack_b1");
      push_exp(7'h07, 9'h101);
      send_byte(8'h01, 1'b1, 1'b0, "b2b_ack_b2");
      i2c_stop();
      chk("b2b_we_count", 32'(we_cnt - we0), 32'd2);
      chk("b2b_queue_drained", 32'(exp_q.size()), 32'd0);

      // Wrong address and read request
      we0 = we_cnt; err0 = err_cnt; oe0 = oe_cnt;
      i2c_start();
      send_byte(8'h36, 1'b0, 1'b0, "wrong_addr_nack");
      send_byte(8'h1E, 1'b0, 1'b0, "wrong_addr_b1_nack");
      i2c_stop();
      i2c_start();
      send_byte(8'h35, 1'b0, 1'b0, "read_nack");
      send_byte(8'h00, 1'b0, 1'b0, "read_b1_nack");
      i2c_stop();
      chk("nomatch_oe_cycles", 32'(oe_cnt - oe0), 32'd0);
      chk("nomatch_we_count", 32'(we_cnt - we0), 32'd0);
      chk("nomatch_err_count", 32'(err_cnt - err0), 32'd0);

      // Truncated frame -> oERR; then repeated START after a full frame -> no oERR
      we0 = we_cnt; err0 = err_cnt;
      i2c_start();
      send_byte(8'h34, 1'b1, 1'b0, "trunc_ack_addr");
      send_byte(8'h12, 1'b1, 1'b0, "trunc_ack_b1");
      i2c_stop();
      chk("trunc_we_count", 32'(we_cnt - we0), 32'd0);
      chk("trunc_err_count", 32'(err_cnt - err0), 32'd1);
      err0 = err_cnt;
      i2c_start();
      send_byte(8'h34, 1'b1, 1'b0, "rs_ack_addr");
      send_byte(8'h12, 1'b1, 1'b0, "rs_ack_b1");
      push_exp(7'h09, 9'h001);
      send_byte(8'h01, 1'b1, 1'b0, "rs_ack_b2");
      i2c_start();
      chk("rs_busy", 32'(busy), 32'd1);
      i2c_stop();
      chk("rs_we_count", 32'(we_cnt - we0), 32'd1);
      chk("rs_err_count", 32'(err_cnt - err0), 32'd0);

      // SCL glitches during byte 1
      we0 = we_cnt;
      i2c_start();
      send_byte(8'h34, 1'b1, 1'b0, "gl_ack_addr");
      send_byte(8'h1E, 1'b1, 1'b1, "gl_ack_b1");
      push_exp(7'h0F, 9'h055);
      send_byte(8'h55, 1'b1, 1'b0, "gl_ack_b2");
      i2c_stop();
      chk("gl_we_count", 32'(we_cnt - we0), 32'd1);

      // Reset while ACKing byte 1
      we0 = we_cnt; err0 = err_cnt;
      i2c_start();
      send_byte(8'h34, 1'b1, 1'b0, "rr_ack_addr");
      send_bits(8'h12, 1'b0);
      m_sda = 1'b1; tick(Q / 2);
      chk("rr_oe_before_rst", 32'(oe), 32'd1);
      rst = 1'b1;
      #1;
      chk("rr_oe_async", 32'(oe), 32'd0);
      chk("rr_addr", 32'(reg_addr), 32'd0);
      chk("rr_data", 32'(reg_data), 32'd0);
      chk("rr_busy", 32'(busy), 32'd0);
      tick(3);
      rst = 1'b0;
      m_scl = 1'b1;
      tick(2 * Q);
      i2c_start();
      send_byte(8'h34, 1'b1, 1'b0, "rr2_ack_addr");
      send_byte(8'h10, 1'b1, 1'b0, "rr2_ack_b1");
      push_exp(7'h08, 9'h003);
      send_byte(8'h03, 1'b1, 1'b0, "rr2_ack_b2");
      i2c_stop();
      chk("rr_we_count", 32'(we_cnt - we0), 32'd1);
      chk("rr_err_count", 32'(err_cnt - err0), 32'd0);

      // Four-byte frame: 4th byte NACKed
      we0 = we_cnt; err0 = err_cnt;
      i2c_start();
      send_byte(8'h34, 1'b1, 1'b0, "f4_ack_addr");
      send_byte(8'h0C, 1'b1, 1'b0, "f4_ack_b1");
      push_exp(7'h06, 9'h000);
      send_byte(8'h00, 1'b1, 1'b0, "f4_ack_b2");
      send_byte(8'hAA, 1'b0, 1'b0, "f4_nack_b3");
      i2c_stop();
      chk("f4_we_count", 32'(we_cnt - we0), 32'd1);
      chk("f4_err_count", 32'(err_cnt - err0), 32'd0);
      chk("final_queue_drained", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
